// File: rtl/pool2d_window_gen_pkg.sv
// ==== pool2d_window_gen_pkg : shared constants for the 2x2 pooling window path ====
// Rev 1.0
`default_nettype none

package pool2d_window_gen_pkg;

  localparam int   BIT_DATA    = 16;
  localparam logic ON          = 1'b1;
  localparam logic OFF         = 1'b0;
  localparam int   POOL_K      = 2;
  localparam int   POOL_STRIDE = 2;

endpackage : pool2d_window_gen_pkg

`default_nettype wire

// File: rtl/pool_row_buffer.sv
// ==== pool_row_buffer : one-row pixel store, one write port, two read ports ====
// Rev 1.0 -- read addresses are expected to come straight from registers, so reads stay combinational.
`default_nettype none

module pool_row_buffer
  import pool2d_window_gen_pkg::*;
#(
  parameter int DATA_W = BIT_DATA,
  parameter int DEPTH  = 28,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]            i_raddr0,
  input  logic [AW-1:0]            i_raddr1,
  output logic signed [DATA_W-1:0] o_rdata0,
  output logic signed [DATA_W-1:0] o_rdata1
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic signed [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule : pool_row_buffer

`default_nettype wire

// File: rtl/pool2d_window_gen.sv
// ==== pool2d_window_gen : raster stream -> non-overlapping 2x2 stride-2 windows ====
// Rev 1.0 -- optional POOL_WIN_FRAME_CNT_EN adds a 16-bit frame counter port.
`default_nettype none

module pool2d_window_gen
  import pool2d_window_gen_pkg::*;
#(
  parameter int DATA_W = BIT_DATA,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic signed [DATA_W-1:0] i_in_data,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  output logic signed [DATA_W-1:0] o_x0,
  output logic signed [DATA_W-1:0] o_x1,
  output logic signed [DATA_W-1:0] o_x2,
  output logic signed [DATA_W-1:0] o_x3,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_frame_done
`ifdef POOL_WIN_FRAME_CNT_EN
  ,
  output logic [15:0]              o_frame_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [DATA_W-1:0] r_hold;
  logic signed [DATA_W-1:0] r_x0, r_x1, r_x2, r_x3;
  logic                     r_out_valid;
  logic                     r_last_win;
  logic                     r_frame_done;

  logic                     w_win_pos;
  logic                     w_last_col;
  logic                     w_last_row;
  logic                     w_out_fire;
  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_load;
  logic                     w_rb_we;
  logic [CW-1:0]            w_col_even;
  logic signed [DATA_W-1:0] w_rb_left;
  logic signed [DATA_W-1:0] w_rb_right;

  assign w_win_pos  = r_row[0] & r_col[0];
  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_row = (r_row == RW'(IMG_H - 1));
  assign w_out_fire = r_out_valid & i_out_ready;
  // Only the window-closing pixel can be held off, and only when the output slot stays occupied.
  assign w_in_ready = ~i_clear & (~w_win_pos | ~r_out_valid | i_out_ready);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_load     = w_accept & w_win_pos;
  assign w_rb_we    = w_accept & ~r_row[0];
  assign w_col_even = r_col & ~CW'(1);

  pool_row_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .AW     (CW)
  ) u_row_buffer (
    .clk      (clk),
    .i_we     (w_rb_we),
    .i_waddr  (r_col),
    .i_wdata  (i_in_data),
    .i_raddr0 (w_col_even),
    .i_raddr1 (r_col),
    .o_rdata0 (w_rb_left),
    .o_rdata1 (w_rb_right)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_x0         <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_x3         <= '0;
      r_out_valid  <= OFF;
      r_last_win   <= OFF;
      r_frame_done <= OFF;
    end else begin
      r_frame_done <= w_out_fire & r_last_win;
      if (i_clear) begin
        r_col       <= '0;
        r_row       <= '0;
        r_out_valid <= OFF;
        r_last_win  <= OFF;
      end else begin
        if (w_accept) begin
          if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
          if (r_row[0] & ~r_col[0]) begin
            r_hold <= i_in_data;
          end
        end
        if (w_load) begin
          r_x0        <= w_rb_left;
          r_x1        <= w_rb_right;
          r_x2        <= r_hold;
          r_x3        <= i_in_data;
          r_out_valid <= ON;
          r_last_win  <= w_last_row & w_last_col;
        end else if (w_out_fire) begin
          r_out_valid <= OFF;
          r_last_win  <= OFF;
        end
      end
    end
  end

`ifdef POOL_WIN_FRAME_CNT_EN
  // Survives clear on purpose: it counts completed frames across restarts.
  logic [15:0] r_frame_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= '0;
    end else if (w_out_fire & r_last_win) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_frame_count = r_frame_count;
`endif

  assign o_in_ready   = w_in_ready;
  assign o_x0         = r_x0;
  assign o_x1         = r_x1;
  assign o_x2         = r_x2;
  assign o_x3         = r_x3;
  assign o_out_valid  = r_out_valid;
  assign o_frame_done = r_frame_done;

endmodule : pool2d_window_gen

`default_nettype wire

// File: tb/tb_pool2d_window_gen.sv
// ==== tb_pool2d_window_gen : randomized + directed bench with a queue-based window model ====
// Rev 1.0
`default_nettype none

module tb_pool2d_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_clear = 1'b0;
  logic signed [DW-1:0] i_in_data = '0;
  logic                 i_in_valid = 1'b0;
  logic                 o_in_ready;
  logic signed [DW-1:0] o_x0, o_x1, o_x2, o_x3;
  logic                 o_out_valid;
  logic                 i_out_ready = 1'b1;
  logic                 o_frame_done;
`ifdef POOL_WIN_FRAME_CNT_EN
  logic [15:0]          o_frame_count;
`endif

  pool2d_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (i_clear),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_x0         (o_x0),
    .o_x1         (o_x1),
    .o_x2         (o_x2),
    .o_x3         (o_x3),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_frame_done (o_frame_done)
`ifdef POOL_WIN_FRAME_CNT_EN
    ,
    .o_frame_count(o_frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0; int x1; int x2; int x3; bit last;
  } win_t;

  int   checks = 0;
  int   fails  = 0;
  win_t q[$];
  win_t wlog[$];
  int   pix [H][W];
  int   m_r = 0, m_c = 0;
  bit   exp_done = 0;
  int   exp_cnt = 0;
  int   cyc = 0, done_cnt = 0, done_cyc = -1, last_fire_cyc = -100;
  bit   rnd_ordy = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: position by pixel count within the frame, windows queued in output order.
  always @(negedge clk) begin
    bit   win, rdy, fire;
    win_t w;
    cyc++;
    if (!rst_n) begin
      chk("rst_out_valid", int'(o_out_valid), 0);
      chk("rst_frame_done", int'(o_frame_done), 0);
      chk("rst_x", int'(o_x0) | int'(o_x1) | int'(o_x2) | int'(o_x3), 0);
      m_r = 0; m_c = 0; q.delete(); exp_done = 0; exp_cnt = 0;
    end else begin
      chk("frame_done", int'(o_frame_done), int'(exp_done));
      if (o_frame_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
`ifdef POOL_WIN_FRAME_CNT_EN
      chk("frame_count", int'(o_frame_count), exp_cnt);
`endif
      chk("out_valid", int'(o_out_valid), int'(q.size() != 0));
      if (q.size() != 0) begin
        chk("x0", int'(o_x0), q[0].x0);
        chk("x1", int'(o_x1), q[0].x1);
        chk("x2", int'(o_x2), q[0].x2);
        chk("x3", int'(o_x3), q[0].x3);
      end
      win = (m_r % 2 == 1) && (m_c % 2 == 1);
      rdy = !i_clear && (!win || q.size() == 0 || i_out_ready);
      chk("in_ready", int'(o_in_ready), int'(rdy));
      fire = (q.size() != 0) && i_out_ready;
      exp_done = 0;
      if (fire) begin
        if (q[0].last) begin exp_done = 1; exp_cnt = (exp_cnt + 1) % 65536; last_fire_cyc = cyc; end
        wlog.push_back(q.pop_front());
      end
      if (i_clear) begin
        m_r = 0; m_c = 0; q.delete();
      end else if (i_in_valid && rdy) begin
        pix[m_r][m_c] = int'(i_in_data);
        if (win) begin
          w.x0 = pix[m_r-1][m_c-1]; w.x1 = pix[m_r-1][m_c];
          w.x2 = pix[m_r][m_c-1];   w.x3 = pix[m_r][m_c];
          w.last = (m_r == H-1) && (m_c == W-1);
          q.push_back(w);
        end
        m_c++;
        if (m_c == W) begin m_c = 0; m_r = (m_r + 1) % H; end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ordy) i_out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input int d, output int stalls);
    bit ok = 0;
    stalls = 0;
    i_in_valid = 1'b1;
    i_in_data  = DW'(d);
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = o_in_ready;
      @(posedge clk); #1;
      if (!ok) stalls++;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    i_in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic stream(input int base, input int n);
    int s;
    for (int p = 0; p < n; p++) send(base + p, s);
    i_in_valid = 1'b0;
  endtask

  task automatic chk_win(string nm, int idx, int a, int b, int c, int d);
    if (idx < wlog.size()) begin
      chk({nm, "_x0"}, wlog[idx].x0, a);
      chk({nm, "_x1"}, wlog[idx].x1, b);
      chk({nm, "_x2"}, wlog[idx].x2, c);
      chk({nm, "_x3"}, wlog[idx].x3, d);
    end else begin
      chk({nm, "_missing"}, wlog.size(), idx + 1);
    end
  endtask

  task automatic do_reset();
    i_in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st [16];
    int s, mx;
    do_reset();

    // Plain frame 0..15, no backpressure.
    wlog.delete(); done_cnt = 0;
    stream(0, 16); idle(4);
    chk("t1_nwin", wlog.size(), 4);
    chk_win("t1_w0", 0, 0, 1, 4, 5);
    chk_win("t1_w1", 1, 2, 3, 6, 7);
    chk_win("t1_w2", 2, 8, 9, 12, 13);
    chk_win("t1_w3", 3, 10, 11, 14, 15);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_lat", done_cyc - last_fire_cyc, 1);

    // Same stream, first window held for 5 cycles.
    wlog.delete(); i_out_ready = 1'b0;
    fork
      begin
        bit seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
          @(negedge clk); seen = o_out_valid;
        end
        if (!seen) chk("t2_valid_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #1 i_out_ready = 1'b1;
      end
      begin
        for (int p = 0; p < 16; p++) send(p, st[p]);
        i_in_valid = 1'b0;
      end
    join
    idle(4);
    s = 0;
    for (int p = 0; p < 16; p++) if (p != 7) s += st[p];
    chk("t2_stall_p7", int'(st[7] > 0), 1);
    chk("t2_stall_other", s, 0);
    chk("t2_nwin", wlog.size(), 4);
    chk_win("t2_w0", 0, 0, 1, 4, 5);
    chk_win("t2_w3", 3, 10, 11, 14, 15);

    // Signed pixels -8..7.
    wlog.delete();
    stream(-8, 16); idle(4);
    chk_win("t3_w0", 0, -8, -7, -4, -3);
    if (wlog.size() > 0) begin
      mx = wlog[0].x0;
      if (wlog[0].x1 > mx) mx = wlog[0].x1;
      if (wlog[0].x2 > mx) mx = wlog[0].x2;
      if (wlog[0].x3 > mx) mx = wlog[0].x3;
      chk("t3_max", mx, -3);
    end

    // Reset mid-frame after pixel 6.
    stream(0, 7);
    do_reset();
    wlog.delete();
    stream(100, 16); idle(4);
    chk("t4_nwin", wlog.size(), 4);
    chk_win("t4_w0", 0, 100, 101, 104, 105);

    // Clear with a pending window and a pixel offered in the same cycle.
    i_out_ready = 1'b0;
    stream(0, 6);
    i_clear = 1'b1; i_in_valid = 1'b1; i_in_data = 8'sd55;
    @(posedge clk); #1;
    i_clear = 1'b0; i_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_clear", int'(o_out_valid), 0);
    @(posedge clk); #1;
    i_out_ready = 1'b1;
    wlog.delete();
    stream(20, 16); idle(4);
    chk("t5_nwin", wlog.size(), 4);
    chk_win("t5_w0", 0, 20, 21, 24, 25);

    // Randomized traffic, gaps, backpressure and one mid-stream clear.
    rnd_ordy = 1;
    for (int p = 0; p < 80; p++) begin
      if (p == 37) begin
        i_clear = 1'b1; i_in_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        i_clear = 1'b0;
      end
      send(int'($signed(8'($urandom_range(0, 255)))), s);
      idle(int'($urandom_range(0, 2)));
    end
    rnd_ordy = 0;
    #1 i_out_ready = 1'b1;
    idle(8);
    chk("t6_drained", int'(o_out_valid), 0);

    // Two back-to-back frames; frame counter steps 0, 1, 2 when present.
    do_reset();
    done_cnt = 0;
`ifdef POOL_WIN_FRAME_CNT_EN
    chk("t7_cnt0", int'(o_frame_count), 0);
`endif
    stream(0, 16); idle(3);
`ifdef POOL_WIN_FRAME_CNT_EN
    chk("t7_cnt1", int'(o_frame_count), 1);
`endif
    stream(50, 16); idle(3);
`ifdef POOL_WIN_FRAME_CNT_EN
    chk("t7_cnt2", int'(o_frame_count), 2);
`endif
    chk("t7_done_cnt", done_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule : tb_pool2d_window_gen

`default_nettype wire

// File: doc/pool2d_window_gen.md
Name: pool2d_window_gen

Overview:
- Producer side of the 2x2 max-pool kernel: accepts a raster-ordered feature-map pixel stream and assembles non-overlapping 2x2, stride-2 windows.
- Presents each window as x0..x3 with a valid/ready handshake.
- Sits between the conv output stream and kernel_max2d.
- Buffers one even row and emits one window per odd-row/odd-column pixel.

Parameters:
- DATA_W, `BIT_DATA, pixel width (signed).
- IMG_W, 28, feature-map width in pixels; must be even and at least 2.
- IMG_H, 28, feature-map height in pixels; must be even and at least 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- clear  in  1  synchronous frame restart; clears counters and output valid.
- in_data  in  DATA_W  signed pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a pixel this cycle.
- x0, x1  out  DATA_W each  window top row: (r-1,c-1), (r-1,c).
- x2, x3  out  DATA_W each  window bottom row: (r,c-1), (r,c).
- out_valid  out  1  x0..x3 hold a window.
- out_ready  in  1  consumer accepts the window.
- frame_done  out  1  one-cycle pulse when the last window of a frame is accepted downstream.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - col=0, row=0, out_valid=0, frame_done=0.
  - x0..x3 = 0.
  - Hold register = 0.
  - Row buffer contents are don't-care.
- A pixel is accepted when in_valid & in_ready.
- Each accepted pixel advances col. At col==IMG_W-1, col wraps to 0 and row increments. At row==IMG_H-1 and col==IMG_W-1, both wrap to 0.
- Even row: the pixel is written to rowbuf[col]. in_ready=1.
- Odd row, even col: the pixel is stored in the hold register. in_ready=1.
- Odd row, odd col:
  - in_ready = !out_valid | out_ready.
  - On accept, the outputs register on the next edge: x0=rowbuf[col-1], x1=rowbuf[col], x2=hold, x3=in_data. out_valid=1.
  - Latency is 1 cycle from accept to out_valid.
- Output handshake:
  - x0..x3 stay stable while out_valid & !out_ready.
  - out_valid drops after acceptance unless a new window loads in the same cycle; back-to-back load is allowed.
- frame_done asserts for 1 cycle after downstream accepts the window formed at (IMG_H-1, IMG_W-1).
- Throughput: 1 pixel per cycle with no backpressure. Output rate is one window per 4 pixels.
- clear=1:
  - Clears col, row and out_valid next cycle. A pending window is discarded.
  - A pixel presented the same cycle is dropped; clear wins.
  - in_ready=0 while clear=1.
- Reset mid-frame: same effect as clear. The next accepted pixel is treated as (0,0).
- No arithmetic is performed. Data passes through bit-exact, signed.
- Counter widths: $clog2(IMG_W) and $clog2(IMG_H).

Optional Feature:
- Macro: POOL_WIN_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_count (16 bits), reset to 0.
  - frame_count increments on each frame_done pulse and wraps from 65535 to 0.
  - clear does not reset it.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared definitions include: BIT_DATA, ON/OFF constants, and new constants POOL_K=2 and POOL_STRIDE=2.
- One sub-module: pool_row_buffer.
  - IMG_W x DATA_W, single write port, two registered-address read ports for col-1 and col.
  - Inferrable as distributed RAM or registers.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15 streamed with out_ready=1:
  - Windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15).
  - frame_done pulses once, 1 cycle after the last window.
- Same stream with out_ready=0 for 5 cycles while the first window is pending:
  - x0..x3 stay at (0,1,4,5).
  - in_ready=0 only at pixel 7; no data is lost.
- Signed data, pixels -8..7:
  - First window is (-8,-7,-4,-3) bit-exact.
  - Feeding kernel_max2d gives y=-3.
- Assert reset after pixel 6, then restart with pixels 100..115:
  - First window is (100,101,104,105).
  - No stale output.
- clear and in_valid high in the same cycle:
  - The pixel is dropped and out_valid=0.
  - The next pixel maps to (0,0).
- Two frames back-to-back with POOL_WIN_FRAME_CNT_EN defined:
  - frame_count goes 0, 1, 2.
  - With the macro undefined, the port is absent and the design elaborates cleanly.
